// File: rtl/operand_sequencer.sv
// Two-operand entry sequencer: debounced ENTER/CLEAR keys latch SW into a_val/b_val
// and present a registered sum for a seven-segment display driver.
module operand_sequencer_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_stable;
  logic          r_stable_q;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync     <= 2'b11;
      r_stable   <= 1'b1;
      r_stable_q <= 1'b1;
      r_cnt      <= '0;
      r_press    <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], i_key_n};
      r_stable_q <= r_stable;
      // Falling edge of the stable level only; releases are ignored.
      r_press    <= r_stable_q & ~r_stable;
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == TC) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;
endmodule

module operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [4:0] SW,
  input  logic       KEY_ENTER,
  input  logic       KEY_CLEAR,
  output logic [4:0] a_val,
  output logic [4:0] b_val,
  output logic [5:0] sum,
  output logic       sum_valid,
  output logic [1:0] phase
);
  typedef enum logic [1:0] {
    GET_A = 2'b00,
    GET_B = 2'b01,
    SHOW  = 2'b10
  } phase_t;

  logic   w_enter_evt;
  logic   w_clear_evt;
  phase_t r_phase;
  logic [4:0] r_a_val;
  logic [4:0] r_b_val;
  logic [5:0] r_sum;
  logic       r_sum_valid;

  operand_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .i_clk   (CLOCK_50),
    .i_rst   (RESET),
    .i_key_n (KEY_ENTER),
    .o_press (w_enter_evt)
  );

  operand_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .i_clk   (CLOCK_50),
    .i_rst   (RESET),
    .i_key_n (KEY_CLEAR),
    .o_press (w_clear_evt)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_phase     <= GET_A;
      r_a_val     <= '0;
      r_b_val     <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else if (w_clear_evt) begin
      // Clear wins over a simultaneous enter.
      r_phase     <= GET_A;
      r_a_val     <= '0;
      r_b_val     <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      case (r_phase)
        GET_A, SHOW: begin
          if (w_enter_evt) begin
            r_phase     <= GET_B;
            r_a_val     <= SW;
            r_b_val     <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
          end
        end
        GET_B: begin
          if (w_enter_evt) begin
            r_phase     <= SHOW;
            r_b_val     <= SW;
            r_sum       <= {1'b0, r_a_val} + {1'b0, SW};
            r_sum_valid <= 1'b1;
          end
        end
        default: begin
          r_phase     <= GET_A;
          r_a_val     <= '0;
          r_b_val     <= '0;
          r_sum       <= '0;
          r_sum_valid <= 1'b0;
        end
      endcase
    end
  end

  assign a_val     = r_a_val;
  assign b_val     = r_b_val;
  assign sum       = r_sum;
  assign sum_valid = r_sum_valid;
  assign phase     = r_phase;
endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a 4-cycle debounce window.
module tb_operand_sequencer;
  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic [4:0] SW;
  logic       KEY_ENTER;
  logic       KEY_CLEAR;
  logic [4:0] a_val;
  logic [4:0] b_val;
  logic [5:0] sum;
  logic       sum_valid;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;

  operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .SW        (SW),
    .KEY_ENTER (KEY_ENTER),
    .KEY_CLEAR (KEY_CLEAR),
    .a_val     (a_val),
    .b_val     (b_val),
    .sum       (sum),
    .sum_valid (sum_valid),
    .phase     (phase)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Hold the selected keys low long enough to debounce, then release and settle.
  task automatic press(input logic enter, input logic clear);
    if (enter) KEY_ENTER = 1'b0;
    if (clear) KEY_CLEAR = 1'b0;
    cycles(12);
    KEY_ENTER = 1'b1;
    KEY_CLEAR = 1'b1;
    cycles(12);
  endtask

  task automatic enter_with(input logic [4:0] v);
    SW = v;
    press(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    RESET = 1'b1; SW = 5'd0; KEY_ENTER = 1'b1; KEY_CLEAR = 1'b1;
    cycles(3);
    RESET = 1'b0;
    cycles(2);
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    checks++; if (a_val !== 5'd0) begin errors++; $display("FAIL reset_a: got %0d expected 0", a_val); end
    checks++; if (b_val !== 5'd0) begin errors++; $display("FAIL reset_b: got %0d expected 0", b_val); end
    checks++; if (sum !== 6'd0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", sum); end
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", sum_valid); end
  endtask

  task automatic test_basic_sum();
    enter_with(5'd21);
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL basic_phase_a: got %0d expected 1", phase); end
    checks++; if (a_val !== 5'd21) begin errors++; $display("FAIL basic_a_latch: got %0d expected 21", a_val); end
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_a: got %0d expected 0", sum_valid); end
    enter_with(5'd10);
    checks++; if (phase !== 2'd2) begin errors++; $display("FAIL basic_phase_b: got %0d expected 2", phase); end
    checks++; if (a_val !== 5'd21) begin errors++; $display("FAIL basic_a: got %0d expected 21", a_val); end
    checks++; if (b_val !== 5'd10) begin errors++; $display("FAIL basic_b: got %0d expected 10", b_val); end
    checks++; if (sum !== 6'd31) begin errors++; $display("FAIL basic_sum: got %0d expected 31", sum); end
    checks++; if (sum_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0d expected 1", sum_valid); end
    SW = 5'd7;
    cycles(20);
    checks++; if (sum !== 6'd31) begin errors++; $display("FAIL hold_sum: got %0d expected 31", sum); end
    checks++; if (b_val !== 5'd10) begin errors++; $display("FAIL hold_b: got %0d expected 10", b_val); end
  endtask

  task automatic test_restart();
    enter_with(5'd5);
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL restart_phase: got %0d expected 1", phase); end
    checks++; if (a_val !== 5'd5) begin errors++; $display("FAIL restart_a: got %0d expected 5", a_val); end
    checks++; if (b_val !== 5'd0) begin errors++; $display("FAIL restart_b: got %0d expected 0", b_val); end
    checks++; if (sum !== 6'd0) begin errors++; $display("FAIL restart_sum: got %0d expected 0", sum); end
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL restart_valid: got %0d expected 0", sum_valid); end
  endtask

  task automatic test_bounce();
    SW = 5'd30;
    for (int i = 0; i < 5; i++) begin
      KEY_ENTER = 1'b0;
      cycles(3);
      KEY_ENTER = 1'b1;
      cycles(3);
    end
    cycles(12);
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL bounce_phase: got %0d expected 1", phase); end
    checks++; if (b_val !== 5'd0) begin errors++; $display("FAIL bounce_b: got %0d expected 0", b_val); end
  endtask

  task automatic test_latency();
    SW = 5'd9;
    KEY_ENTER = 1'b0;
    cycles(7);
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL latency_early: got %0d expected 1", phase); end
    cycles(1);
    checks++; if (phase !== 2'd2) begin errors++; $display("FAIL latency_event: got %0d expected 2", phase); end
    checks++; if (sum !== 6'd14) begin errors++; $display("FAIL latency_sum: got %0d expected 14", sum); end
    cycles(20);
    checks++; if (phase !== 2'd2) begin errors++; $display("FAIL held_single_event: got %0d expected 2", phase); end
    KEY_ENTER = 1'b1;
    cycles(12);
    checks++; if (phase !== 2'd2) begin errors++; $display("FAIL release_no_event: got %0d expected 2", phase); end
  endtask

  task automatic test_boundary();
    press(1'b0, 1'b1);
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL clear_phase: got %0d expected 0", phase); end
    checks++; if (sum !== 6'd0) begin errors++; $display("FAIL clear_sum: got %0d expected 0", sum); end
    checks++; if (a_val !== 5'd0) begin errors++; $display("FAIL clear_a: got %0d expected 0", a_val); end
    enter_with(5'd31);
    enter_with(5'd31);
    checks++; if (sum !== 6'd62) begin errors++; $display("FAIL max_sum: got %0d expected 62", sum); end
    checks++; if (sum_valid !== 1'b1) begin errors++; $display("FAIL max_valid: got %0d expected 1", sum_valid); end
    press(1'b0, 1'b1);
    enter_with(5'd0);
    enter_with(5'd0);
    checks++; if (sum !== 6'd0) begin errors++; $display("FAIL zero_sum: got %0d expected 0", sum); end
    checks++; if (sum_valid !== 1'b1) begin errors++; $display("FAIL zero_valid: got %0d expected 1", sum_valid); end
    checks++; if (phase !== 2'd2) begin errors++; $display("FAIL zero_phase: got %0d expected 2", phase); end
  endtask

  task automatic test_priority();
    press(1'b0, 1'b1);
    enter_with(5'd12);
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL prio_setup: got %0d expected 1", phase); end
    SW = 5'd3;
    press(1'b1, 1'b1);
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL prio_phase: got %0d expected 0", phase); end
    checks++; if (a_val !== 5'd0) begin errors++; $display("FAIL prio_a: got %0d expected 0", a_val); end
    checks++; if (b_val !== 5'd0) begin errors++; $display("FAIL prio_b: got %0d expected 0", b_val); end
    checks++; if (sum !== 6'd0) begin errors++; $display("FAIL prio_sum: got %0d expected 0", sum); end
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL prio_valid: got %0d expected 0", sum_valid); end
  endtask

  task automatic test_reset_mid();
    enter_with(5'd20);
    enter_with(5'd30);
    checks++; if (sum !== 6'd50) begin errors++; $display("FAIL rmid_setup: got %0d expected 50", sum); end
    KEY_ENTER = 1'b0;
    cycles(2);
    RESET = 1'b1;
    #1;
    checks++; if (sum !== 6'd0) begin errors++; $display("FAIL rmid_async_sum: got %0d expected 0", sum); end
    checks++; if (a_val !== 5'd0) begin errors++; $display("FAIL rmid_async_a: got %0d expected 0", a_val); end
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valid: got %0d expected 0", sum_valid); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL rmid_async_phase: got %0d expected 0", phase); end
    cycles(1);
    KEY_ENTER = 1'b1;
    RESET = 1'b0;
    cycles(15);
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL rmid_no_event: got %0d expected 0", phase); end
    KEY_ENTER = 1'b0;
    cycles(1);
    RESET = 1'b1;
    cycles(2);
    SW = 5'd17;
    RESET = 1'b0;
    cycles(7);
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL rheld_early: got %0d expected 0", phase); end
    cycles(1);
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL rheld_event: got %0d expected 1", phase); end
    checks++; if (a_val !== 5'd17) begin errors++; $display("FAIL rheld_a: got %0d expected 17", a_val); end
    KEY_ENTER = 1'b1;
    cycles(12);
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL rheld_single: got %0d expected 1", phase); end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_restart();
    test_bounce();
    test_latency();
    test_boundary();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
